spart_tx: RTL and testbench
===========================

SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, rate_en pulses per serial bit time.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rate_en  input  1  one-cycle baud tick from the baud rate generator, at OVERSAMPLE x baud.
REQ-005 iocs  input  1  chip select for the SPART register bus.
REQ-006 iorw  input  1  bus direction: 0 = write, 1 = read.
REQ-007 ioaddr  input  2  register select; 2'b00 = IO_XFER, the transmit data register.
REQ-008 databus_in  input  8  write data from the processor.
REQ-009 txd  output  1  serial line, idle high, registered.
REQ-010 tbr  output  1  transmit buffer ready: 1 = holding register empty and may be written.

Function
REQ-011 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-012 Each bit SHALL last exactly OVERSAMPLE rate_en pulses, counted by a tick counter of width clog2(OVERSAMPLE) that wraps to 0 on the bit's final tick.
REQ-013 A write SHALL be iocs=1, iorw=0, ioaddr=2'b00 while tbr=1; it captures databus_in into the holding register and drives tbr=0 on the next cycle.
REQ-014 A write attempted while tbr=0, or any access with iorw=1 or ioaddr!=2'b00, SHALL be ignored with no state change.
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE: txd=1; when the holding register is full, next cycle SHALL be START. At the transition, the holding register copies into the shift register, tbr returns to 1, and the tick and bit counters clear.
REQ-017 START: txd=0; after OVERSAMPLE ticks -> DATA.
REQ-018 DATA: txd=shift[0]; on each bit's final tick, the shift register shifts right and the 3-bit bit counter increments; after the 8th bit's final tick (count 7) -> STOP.
REQ-019 STOP: txd=1; on the final tick, if the holding register is full -> START with the same transfer actions as REQ-016 (back-to-back, no idle gap); otherwise -> IDLE.
REQ-020 Latency: a write in IDLE at cycle N SHALL make the holding register full at N+1 and drive txd=0 from cycle N+2.
REQ-021 Simultaneous write and transfer SHALL be impossible: writes require an empty holding register, and transfer requires a full one.
REQ-022 A write accepted during START/DATA/STOP SHALL NOT disturb the frame in flight.
REQ-023 rate_en asserted on consecutive cycles SHALL count each cycle as a tick; with rate_en held low, the FSM SHALL hold state and txd indefinitely.
REQ-024 The bus interface SHALL have no read data path; read data is owned by the receiver/bus mux.

Reset
REQ-025 With rst=1 at a clock edge, the next cycle SHALL give: state=IDLE, txd=1, tbr=1, holding register empty, shift register=8'h00, all counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately; the holding register contents are discarded.
REQ-027 Writes presented while rst=1 SHALL be ignored.

Verification
REQ-028 Single byte: write 8'hA5 in IDLE, rate_en every 4th cycle -> txd pattern 0,1,0,1,0,0,1,0,1,1; each level lasts 16 ticks (64 clk); tbr returns to 1 two cycles after the write.
REQ-029 Back-to-back: write 8'h55, then write 8'h0F once tbr=1 -> second start bit begins on the cycle after the first stop bit's 16th tick, with no idle ticks between frames.
REQ-030 Overrun: write 8'h11 and 8'h22, then attempt 8'h33 while tbr=0 -> 8'h33 is never transmitted, and the line carries 8'h11 then 8'h22 only.
REQ-031 Decode filter: iocs=1, iorw=0, ioaddr=2'b01, data 8'hFF; then iorw=1, ioaddr=2'b00 -> tbr stays 1 and txd stays 1.
REQ-032 Reset mid-frame: rst=1 for one cycle during the 3rd data bit of 8'hC3 -> next cycle txd=1, tbr=1; a new write of 8'h3C then transmits a clean full frame.
REQ-033 Stalled ticks: rate_en held low for 1000 cycles mid-START -> txd holds 0; the bit completes after the remaining ticks once rate_en resumes.

Source files
------------

// File: rtl/spart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : spart_tx_if
// Brief    : SPART register-bus signals seen by the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface spart_tx_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] databus_in;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, output databus_in, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, input databus_in, output tbr);
endinterface
`default_nettype wire

// File: rtl/spart_tx.sv
`default_nettype none
// ============================================================================
// Module   : spart_tx
// Brief    : SPART transmitter - holding register, 8N1 serializer on txd.
// Revision : 1.0 - initial release
// ============================================================================
module spart_tx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rate_en,
    spart_tx_if.slave  bus,
    output logic       txd
);

    localparam int                  c_TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]          r_state, w_state_next;
    logic [7:0]          r_hold, r_shift, w_shift_next;
    logic                r_full, r_txd, w_txd_next;
    logic [c_TICK_W-1:0] r_tick, w_tick_next;
    logic [2:0]          r_bit, w_bit_next;
    logic                w_wr, w_last_tick, w_load;

    // Writes only land in an empty holding register, loads only take a full one,
    // so the two can never happen in the same cycle.
    assign w_wr        = bus.iocs & ~bus.iorw & (bus.ioaddr == 2'b00) & ~r_full;
    assign w_last_tick = rate_en & (r_tick == c_TICK_LAST);
    assign w_load      = r_full & ((r_state == c_IDLE) | ((r_state == c_STOP) & w_last_tick));

    assign bus.tbr = ~r_full;
    assign txd     = r_txd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (r_full) w_state_next = c_START;
            c_START: if (w_last_tick) w_state_next = c_DATA;
            c_DATA:  if (w_last_tick && (r_bit == 3'd7)) w_state_next = c_STOP;
            c_STOP:  if (w_last_tick) w_state_next = r_full ? c_START : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // txd is registered from the next state so the start bit appears the same
    // cycle the FSM enters START.
    always_comb begin
        w_shift_next = r_shift;
        w_tick_next  = r_tick;
        w_bit_next   = r_bit;
        if (w_load) begin
            w_shift_next = r_hold;
            w_tick_next  = '0;
            w_bit_next   = 3'd0;
        end else if ((r_state != c_IDLE) && rate_en) begin
            w_tick_next = w_last_tick ? '0 : r_tick + 1'b1;
            if ((r_state == c_DATA) && w_last_tick) begin
                w_shift_next = {1'b0, r_shift[7:1]};
                w_bit_next   = r_bit + 3'd1;
            end
        end
        case (w_state_next)
            c_START: w_txd_next = 1'b0;
            c_DATA:  w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold  <= 8'h00;
            r_full  <= 1'b0;
            r_shift <= 8'h00;
            r_tick  <= '0;
            r_bit   <= 3'd0;
            r_txd   <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            r_tick  <= w_tick_next;
            r_bit   <= w_bit_next;
            r_txd   <= w_txd_next;
            if (w_wr) begin
                r_hold <= bus.databus_in;
                r_full <= 1'b1;
            end else if (w_load) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_tx
// Brief    : Directed self-checking bench for spart_tx (OVERSAMPLE = 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_on;
    logic [1:0] r_div = 2'd0;
    logic       rate_en;
    logic       txd;

    int n_checks = 0;
    int n_errors = 0;

    spart_tx_if bus_if ();

    spart_tx #(.OVERSAMPLE(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .rate_en (rate_en),
        .bus     (bus_if),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    // Baud tick on every 4th clock -> one bit = 16 ticks = 64 clocks.
    always @(posedge clk) r_div <= r_div + 2'd1;
    assign rate_en = tick_on & (r_div == 2'd3);

    // Line monitor: length in clocks of every completed txd level.
    int   runs[$];
    int   cyc       = 0;
    int   run_start = 0;
    logic mon_lvl   = 1'b1;
    always @(posedge clk) begin
        #3;
        cyc++;
        if (txd !== mon_lvl) begin
            runs.push_back(cyc - run_start);
            run_start = cyc;
            mon_lvl   = txd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] d);
        @(negedge clk);
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00; bus_if.databus_in = d;
        @(negedge clk);
        bus_if.iocs = 1'b0;
    endtask

    task automatic wait_tbr(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (bus_if.tbr === 1'b1) break;
            @(negedge clk);
        end
        check(tag, bus_if.tbr, 1'b1);
    endtask

    task automatic wait_txd_low(input string tag);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (txd === 1'b0) break;
        end
        check(tag, txd, 1'b0);
    endtask

    task automatic wait_runs(input int n, input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (runs.size() >= n) break;
            @(negedge clk);
        end
        check(tag, runs.size() >= n, 1'b1);
    endtask

    // Mid-bit sampling receiver; returns at the middle of the stop bit.
    task automatic rx_frame(input int timeout, output logic [7:0] d, output logic stop_bit, output logic got);
        got = 1'b0; d = 8'h00; stop_bit = 1'b0;
        for (int i = 0; i < timeout; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            repeat (32) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (64) @(negedge clk);
                d[b] = txd;
            end
            repeat (64) @(negedge clk);
            stop_bit = txd;
        end
    endtask

    logic [7:0] rx_d;
    logic       rx_stop, rx_got, held_ok;

    initial begin
        rst = 1'b1; tick_on = 1'b1;
        bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00; bus_if.databus_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_tbr", bus_if.tbr, 1'b1);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single byte with latency and bit-length checks
        runs.delete();
        bus_write(8'hA5);
        check("a5_tbr_busy", bus_if.tbr, 1'b0);
        check("a5_txd_idle", txd, 1'b1);
        @(negedge clk);
        check("a5_tbr_back", bus_if.tbr, 1'b1);
        check("a5_start", txd, 1'b0);
        wait_runs(8, "a5_runs_wait");
        check("a5_run_b0", runs[2], 64);
        check("a5_run_b1", runs[3], 64);
        check("a5_run_b2", runs[4], 64);
        check("a5_run_b34", runs[5], 128);
        check("a5_run_b5", runs[6], 64);
        check("a5_run_b6", runs[7], 64);
        repeat (200) @(negedge clk);
        check("a5_idle_txd", txd, 1'b1);

        // Back-to-back frames
        runs.delete();
        bus_write(8'h55);
        wait_tbr("b2b_tbr_wait");
        bus_write(8'h0F);
        rx_frame(2000, rx_d, rx_stop, rx_got);
        check("b2b_f1_got", rx_got, 1'b1);
        check("b2b_f1_data", rx_d, 8'h55);
        check("b2b_f1_stop", rx_stop, 1'b1);
        rx_frame(200, rx_d, rx_stop, rx_got);
        check("b2b_f2_got", rx_got, 1'b1);
        check("b2b_f2_data", rx_d, 8'h0F);
        wait_runs(14, "b2b_runs_wait");
        check("b2b_stop_len", runs[10], 64);
        check("b2b_start2_len", runs[11], 64);
        check("b2b_ones_len", runs[12], 256);
        check("b2b_zeros_len", runs[13], 256);
        repeat (100) @(negedge clk);

        // Overrun: third write while holding register is full is dropped
        bus_write(8'h11);
        wait_tbr("ovr_tbr_wait");
        bus_write(8'h22);
        check("ovr_tbr_full", bus_if.tbr, 1'b0);
        bus_write(8'h33);
        check("ovr_tbr_still_full", bus_if.tbr, 1'b0);
        rx_frame(2000, rx_d, rx_stop, rx_got);
        check("ovr_f1_data", rx_d, 8'h11);
        rx_frame(200, rx_d, rx_stop, rx_got);
        check("ovr_f2_data", rx_d, 8'h22);
        check("ovr_f2_stop", rx_stop, 1'b1);
        rx_frame(1200, rx_d, rx_stop, rx_got);
        check("ovr_no_f3", rx_got, 1'b0);
        check("ovr_tbr_end", bus_if.tbr, 1'b1);

        // Decode filter: wrong address, read, deselected
        @(negedge clk);
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b01; bus_if.databus_in = 8'hFF;
        @(negedge clk);
        bus_if.iorw = 1'b1; bus_if.ioaddr = 2'b00;
        @(negedge clk);
        bus_if.iocs = 1'b0; bus_if.iorw = 1'b0;
        @(negedge clk);
        check("dec_tbr", bus_if.tbr, 1'b1);
        check("dec_txd", txd, 1'b1);
        rx_frame(300, rx_d, rx_stop, rx_got);
        check("dec_no_frame", rx_got, 1'b0);

        // Reset mid-frame discards frame and pending byte
        bus_write(8'hC3);
        wait_txd_low("rst_start_wait");
        bus_write(8'h99);
        repeat (220) @(negedge clk);
        check("rst_bit2", txd, 1'b0);
        rst = 1'b1;
        bus_if.iocs = 1'b1; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00; bus_if.databus_in = 8'hEE;
        @(negedge clk);
        rst = 1'b0; bus_if.iocs = 1'b0;
        check("rst_txd", txd, 1'b1);
        check("rst_tbr", bus_if.tbr, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_hold_empty", bus_if.tbr, 1'b1);
        check("rst_no_restart", txd, 1'b1);
        bus_write(8'h3C);
        rx_frame(2000, rx_d, rx_stop, rx_got);
        check("rst_new_data", rx_d, 8'h3C);
        check("rst_new_stop", rx_stop, 1'b1);
        repeat (100) @(negedge clk);

        // Stalled ticks in START
        runs.delete();
        bus_write(8'h01);
        wait_txd_low("stall_start_wait");
        repeat (20) @(negedge clk);
        tick_on = 1'b0;
        held_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (txd !== 1'b0) held_ok = 1'b0;
        end
        tick_on = 1'b1;
        check("stall_held", held_ok, 1'b1);
        wait_runs(4, "stall_runs_wait");
        check("stall_start_len", (runs[1] >= 1061) && (runs[1] <= 1064), 1'b1);
        check("stall_b0_len", runs[2], 64);
        check("stall_zeros_len", runs[3], 448);
        repeat (100) @(negedge clk);
        check("stall_idle", txd, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
